// File: rtl/rdm_pkg.sv
// Shared definitions for the LLR cache writer (rate-dematching feeder).
// Holds the FSM state encoding, the LLRs-per-word packing factor, the
// largest accepted segment length and the cache bank index type.
package rdm_pkg;

  localparam int LLRS_PER_WORD = 6;
  localparam int MAX_SEG_LEN   = 6144;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BANK = 2'd1,
    ST_FILL      = 2'd2,
    ST_REQ       = 2'd3
  } rdm_state_e;

  typedef logic bank_t;

endpackage

// File: rtl/rdm_llr_word_packer.sv
// Packs accepted LLRs into cache words, lane 0 (LSBs) first.
// Optional feature macro: RDM_LLR_CLIP_EN -- when defined, the most negative
// LLR code is replaced by its symmetric neighbour before packing.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        restart packing at lane 0 with an empty word (new segment)
//   accept       an LLR is taken this cycle
//   last         the accepted LLR is the final one of the segment
//   llr          LLR value
//   closing      combinational: this accept completes or flushes a word
//   word_wr      registered write strobe, one cycle after the closing accept
//   word_data    registered packed word, unused lanes zero on a flush
//
// DATA_WIDTH must equal LLR_WIDTH * LLRS_PER_WORD.
module rdm_llr_word_packer
  import rdm_pkg::*;
#(
  parameter int LLR_WIDTH  = 8,
  parameter int DATA_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  accept,
  input  logic                  last,
  input  logic [LLR_WIDTH-1:0]  llr,
  output logic                  closing,
  output logic                  word_wr,
  output logic [DATA_WIDTH-1:0] word_data
);

  logic [2:0]            lane_q;
  logic [DATA_WIDTH-1:0] pack_q;
  logic [DATA_WIDTH-1:0] pack_next;
  logic [LLR_WIDTH-1:0]  llr_use;
  logic                  word_full;

  always_comb begin
    llr_use = llr;
`ifdef RDM_LLR_CLIP_EN
    // Keep the LLR range symmetric: -2^(W-1) becomes -(2^(W-1)-1).
    if (llr == {1'b1, {(LLR_WIDTH-1){1'b0}}}) begin
      llr_use = {1'b1, {(LLR_WIDTH-2){1'b0}}, 1'b1};
    end
`else
    llr_use = llr;
`endif
  end

  always_comb begin
    pack_next = pack_q;
    pack_next[int'(lane_q)*LLR_WIDTH +: LLR_WIDTH] = llr_use;
  end

  assign word_full = (lane_q == 3'(LLRS_PER_WORD - 1));
  assign closing   = accept && (word_full || last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q    <= '0;
      pack_q    <= '0;
      word_wr   <= 1'b0;
      word_data <= '0;
    end else begin
      word_wr <= 1'b0;
      if (clear) begin
        lane_q <= '0;
        pack_q <= '0;
      end else if (accept) begin
        if (closing) begin
          // pack_q is already zero above the current lane, so a flush
          // naturally pads the unused lanes with zero.
          word_wr   <= 1'b1;
          word_data <= pack_next;
          lane_q    <= '0;
          pack_q    <= '0;
        end else begin
          lane_q <= lane_q + 3'd1;
          pack_q <= pack_next;
        end
      end
    end
  end

endmodule

// File: rtl/rdm_llr_cache_wr.sv
// LLR cache writer: packs a per-user LLR stream six-per-word into a
// ping-pong (two-bank) cache and requests rate dematching per segment.
// Optional feature macro: RDM_LLR_CLIP_EN (LLR clipping inside the packer).
//
// Ports:
//   i_core_clk, i_rx_rstn        clock, asynchronous active-low reset
//   i_seg_start/user_idx/len     segment open pulse with user and length
//   i_llr_valid/data, o_llr_ready LLR stream; an LLR transfers on a cycle
//                                where valid and ready are both high, ready
//                                does not depend on valid, and valid with
//                                ready low is simply not consumed
//   o_ram_wr_en/addr/data        cache write port, addr = {bank, word}
//   o_rdm_req/user_idx/bank/word_cnt  pending segment request; fields are
//                                held stable and read zero when no request
//   i_rdm_ack                    request taken (honoured while o_rdm_req=1)
//   i_rdm_done/done_bank         bank release pulse
//   o_seg_err                    registered pulse for a rejected start
module rdm_llr_cache_wr
  import rdm_pkg::*;
#(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 11,
  parameter int LLR_WIDTH  = 8
) (
  input  logic                  i_core_clk,
  input  logic                  i_rx_rstn,
  input  logic                  i_seg_start,
  input  logic [3:0]            i_seg_user_idx,
  input  logic [15:0]           i_seg_len,
  input  logic                  i_llr_valid,
  input  logic [LLR_WIDTH-1:0]  i_llr_data,
  output logic                  o_llr_ready,
  output logic                  o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wr_data,
  output logic                  o_rdm_req,
  output logic [3:0]            o_rdm_user_idx,
  output logic                  o_rdm_bank,
  output logic [ADDR_WIDTH-1:0] o_rdm_word_cnt,
  input  logic                  i_rdm_ack,
  input  logic                  i_rdm_done,
  input  logic                  i_rdm_done_bank,
  output logic                  o_seg_err
);

  rdm_state_e            state_q;
  bank_t                 ptr_q;
  logic [1:0]            bank_full_q;
  logic [1:0]            bank_full_next;
  logic [3:0]            user_q;
  logic [15:0]           len_q;
  logic [15:0]           cnt_q;
  logic [ADDR_WIDTH-1:0] word_cnt_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  req_q;
  logic                  err_q;
  logic                  accept;
  logic                  last;
  logic                  len_bad;
  logic                  seg_open;
  logic                  bank_free;
  logic                  closing;

  assign o_llr_ready = (state_q == ST_FILL);
  assign accept      = i_llr_valid && o_llr_ready;
  assign last        = accept && ((cnt_q + 16'd1) == len_q);
  assign len_bad     = (i_seg_len == 16'd0) || (i_seg_len > 16'(MAX_SEG_LEN));
  assign seg_open    = (state_q == ST_IDLE) && i_seg_start && !len_bad;
  // A release of the awaited bank in this cycle counts as free, so FILL is
  // entered on the next cycle instead of one cycle later.
  assign bank_free   = !bank_full_q[ptr_q] ||
                       (i_rdm_done && (i_rdm_done_bank == ptr_q));

  always_comb begin
    bank_full_next = bank_full_q;
    if (last) bank_full_next[ptr_q] = 1'b1;
    if (i_rdm_done) bank_full_next[i_rdm_done_bank] = 1'b0;
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      bank_full_q <= '0;
      user_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      word_cnt_q  <= '0;
      wr_addr_q   <= '0;
      req_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q       <= 1'b0;
      bank_full_q <= bank_full_next;
      case (state_q)
        ST_IDLE: begin
          if (i_seg_start) begin
            if (len_bad) begin
              err_q <= 1'b1;
            end else begin
              user_q     <= i_seg_user_idx;
              len_q      <= i_seg_len;
              cnt_q      <= '0;
              word_cnt_q <= '0;
              state_q    <= bank_full_q[ptr_q] ? ST_WAIT_BANK : ST_FILL;
            end
          end
        end
        ST_WAIT_BANK: if (bank_free) state_q <= ST_FILL;
        ST_FILL: begin
          if (accept) begin
            cnt_q <= cnt_q + 16'd1;
            if (last) state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          // First REQ cycle coincides with the final RAM write; the request
          // rises one cycle later so the data is already in the cache.
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (i_rdm_ack) begin
            req_q   <= 1'b0;
            ptr_q   <= ~ptr_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (i_seg_start && (state_q != ST_IDLE)) err_q <= 1'b1;
      if (closing) begin
        wr_addr_q  <= {ptr_q, word_cnt_q[ADDR_WIDTH-2:0]};
        word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  rdm_llr_word_packer #(
    .LLR_WIDTH  (LLR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk       (i_core_clk),
    .rst_n     (i_rx_rstn),
    .clear     (seg_open),
    .accept    (accept),
    .last      (last),
    .llr       (i_llr_data),
    .closing   (closing),
    .word_wr   (o_ram_wr_en),
    .word_data (o_ram_wr_data)
  );

  assign o_ram_wr_addr  = wr_addr_q;
  assign o_rdm_req      = req_q;
  assign o_rdm_user_idx = req_q ? user_q : 4'd0;
  assign o_rdm_bank     = req_q & ptr_q;
  assign o_rdm_word_cnt = req_q ? word_cnt_q : '0;
  assign o_seg_err      = err_q;

endmodule
